// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the regfile port arbiter: FSM encoding, requester IDs,
// statistics counter width.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam int STAT_W = 16;

endpackage

// File: rtl/regfile_arb_pick.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester named by rr_ptr wins.
module regfile_arb_pick
  import regfile_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = valid0 & (~valid1 | (rr_ptr == REQ_CORE));
  assign gnt1 = valid1 & (~valid0 | (rr_ptr == REQ_DBG));

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the core and debug requesters onto one regfile port set with
// round-robin plus bounded burst lock. Optional stats: REGFILE_ARB_STATS_EN.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 5,
  parameter int MAX_LOCK = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_write,
  input  logic                req0_lock,
  input  logic [REG_BITS-1:0] req0_a_idx,
  input  logic [REG_BITS-1:0] req0_b_idx,
  input  logic [WIDTH-1:0]    req0_wdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_write,
  input  logic                req1_lock,
  input  logic [REG_BITS-1:0] req1_a_idx,
  input  logic [REG_BITS-1:0] req1_b_idx,
  input  logic [WIDTH-1:0]    req1_wdata,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [WIDTH-1:0]    rsp_a_data,
  output logic [WIDTH-1:0]    rsp_b_data,
  output logic                rf_reg_write,
  output logic [REG_BITS-1:0] rf_a_idx,
  output logic [REG_BITS-1:0] rf_b_idx,
  output logic [WIDTH-1:0]    rf_wdata,
  input  logic [WIDTH-1:0]    rf_a_data,
  input  logic [WIDTH-1:0]    rf_b_data
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_grant0,
  output logic [STAT_W-1:0]   stat_grant1,
  output logic [STAT_W-1:0]   stat_conflict
`endif
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  function automatic logic [CNT_W-1:0] lock_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  arb_state_e       state, state_nx;
  logic             rr_ptr, rr_nx;
  logic [CNT_W-1:0] lock_cnt, cnt_nx;
  logic             gnt0, gnt1, pick_g0, pick_g1;
  logic             acc0, acc1;

  regfile_arb_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .rr_ptr (rr_ptr),
    .gnt0   (pick_g0),
    .gnt1   (pick_g1)
  );

  // Grant / next-state; reset holds every grant low so nothing reaches the regfile
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_nx = state;
    rr_nx    = rr_ptr;
    cnt_nx   = lock_cnt;
    if (!reset) begin
      case (state)
        ARB: begin
          gnt0 = pick_g0;
          gnt1 = pick_g1;
          if (req0_valid & req1_valid) rr_nx = ~rr_ptr;
          if (pick_g0 & req0_lock) begin
            state_nx = LOCK0;
            cnt_nx   = CNT_W'(1);
          end else if (pick_g1 & req1_lock) begin
            state_nx = LOCK1;
            cnt_nx   = CNT_W'(1);
          end
        end
        LOCK0: begin
          // Forced release: the waiting side takes this very cycle
          if ((lock_cnt == CNT_MAX) && req1_valid) begin
            gnt1     = 1'b1;
            rr_nx    = REQ_CORE;
            state_nx = req1_lock ? LOCK1 : ARB;
            if (req1_lock) cnt_nx = CNT_W'(1);
          end else begin
            gnt0 = 1'b1;
            if (req0_valid) begin
              if (req0_lock) cnt_nx = lock_sat_inc(lock_cnt);
              else           state_nx = ARB;
            end else if (!req0_lock) begin
              state_nx = ARB;
            end
          end
        end
        LOCK1: begin
          if ((lock_cnt == CNT_MAX) && req0_valid) begin
            gnt0     = 1'b1;
            rr_nx    = REQ_DBG;
            state_nx = req0_lock ? LOCK0 : ARB;
            if (req0_lock) cnt_nx = CNT_W'(1);
          end else begin
            gnt1 = 1'b1;
            if (req1_valid) begin
              if (req1_lock) cnt_nx = lock_sat_inc(lock_cnt);
              else           state_nx = ARB;
            end else if (!req1_lock) begin
              state_nx = ARB;
            end
          end
        end
        default: state_nx = ARB;
      endcase
    end
  end

  assign acc0       = req0_valid & gnt0;
  assign acc1       = req1_valid & gnt1;
  assign req0_ready = acc0;
  assign req1_ready = acc1;

  // Regfile port mux; r0 writes are acknowledged but never enabled
  always_comb begin
    rf_reg_write = 1'b0;
    rf_a_idx     = '0;
    rf_b_idx     = '0;
    rf_wdata     = '0;
    if (acc0) begin
      rf_reg_write = req0_write & (req0_a_idx != '0);
      rf_a_idx     = req0_a_idx;
      rf_b_idx     = req0_b_idx;
      rf_wdata     = req0_wdata;
    end else if (acc1) begin
      rf_reg_write = req1_write & (req1_a_idx != '0);
      rf_a_idx     = req1_a_idx;
      rf_b_idx     = req1_b_idx;
      rf_wdata     = req1_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      rr_ptr   <= REQ_CORE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      lock_cnt <= cnt_nx;
    end
  end

  // Response stage: read data sampled at the accept edge (pre-write value)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_a_data <= '0;
      rsp_b_data <= '0;
    end else begin
      rsp0_valid <= acc0;
      rsp1_valid <= acc1;
      if (acc0 | acc1) begin
        rsp_a_data <= rf_a_data;
        rsp_b_data <= rf_b_data;
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + STAT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (acc0) stat_grant0 <= stat_grant0 + STAT_W'(1);
      if (acc1) stat_grant1 <= stat_grant1 + STAT_W'(1);
      if (req0_valid & req1_valid & ~(acc0 & acc1))
        stat_conflict <= stat_sat_inc(stat_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a plain memory standing in
// for the regfile; stats checks are built when REGFILE_ARB_STATS_EN is set.
module tb_regfile_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req0_write, req0_lock;
  logic [4:0]  req0_a_idx, req0_b_idx;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_write, req1_lock;
  logic [4:0]  req1_a_idx, req1_b_idx;
  logic [15:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_a_data, rsp_b_data;
  logic        rf_reg_write;
  logic [4:0]  rf_a_idx, rf_b_idx;
  logic [15:0] rf_wdata, rf_a_data, rf_b_data;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int checks;
  int errs;

  logic [15:0] mem [32];

  regfile_port_arbiter #(.WIDTH(16), .REG_BITS(5), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_lock(req0_lock), .req0_a_idx(req0_a_idx), .req0_b_idx(req0_b_idx),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_lock(req1_lock), .req1_a_idx(req1_a_idx), .req1_b_idx(req1_b_idx),
    .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_a_data(rsp_a_data), .rsp_b_data(rsp_b_data),
    .rf_reg_write(rf_reg_write), .rf_a_idx(rf_a_idx), .rf_b_idx(rf_b_idx),
    .rf_wdata(rf_wdata), .rf_a_data(rf_a_data), .rf_b_data(rf_b_data)
`ifdef REGFILE_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile stand-in: combinational reads, clocked write, cleared while reset is high
  assign rf_a_data = mem[rf_a_idx];
  assign rf_b_data = mem[rf_b_idx];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0;
    end else if (rf_reg_write) begin
      mem[rf_a_idx] <= rf_wdata;
    end
  end

  task automatic drv0(input logic v, input logic w, input logic l,
                      input logic [4:0] a, input logic [4:0] b, input logic [15:0] d);
    req0_valid = v; req0_write = w; req0_lock = l;
    req0_a_idx = a; req0_b_idx = b; req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic w, input logic l,
                      input logic [4:0] a, input logic [4:0] b, input logic [15:0] d);
    req1_valid = v; req1_write = w; req1_lock = l;
    req1_a_idx = a; req1_b_idx = b; req1_wdata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    drv1(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv0(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 16'hAAAA);
    step();
    step();
    checks++; if (rsp0_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp0_valid got=%0h exp=0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp1_valid got=%0h exp=0", rsp1_valid); end
    checks++; if (rsp_a_data !== 16'h0) begin errs++; $display("FAIL rst_rsp_a got=%h exp=0000", rsp_a_data); end
    checks++; if (rsp_b_data !== 16'h0) begin errs++; $display("FAIL rst_rsp_b got=%h exp=0000", rsp_b_data); end
    checks++; if (req0_ready !== 1'b0) begin errs++; $display("FAIL rst_ready0 got=%0h exp=0", req0_ready); end
    checks++; if (rf_reg_write !== 1'b0) begin errs++; $display("FAIL rst_rf_we got=%0h exp=0", rf_reg_write); end
    idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    drv0(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 16'hBEEF);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL wr_ready0 got=%0h exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errs++; $display("FAIL wr_ready1 got=%0h exp=0", req1_ready); end
    checks++; if (rf_reg_write !== 1'b1) begin errs++; $display("FAIL wr_rf_we got=%0h exp=1", rf_reg_write); end
    checks++; if (rf_a_idx !== 5'd3) begin errs++; $display("FAIL wr_rf_a_idx got=%0d exp=3", rf_a_idx); end
    checks++; if (rf_wdata !== 16'hBEEF) begin errs++; $display("FAIL wr_rf_wdata got=%h exp=beef", rf_wdata); end
    step();
    checks++; if (rsp0_valid !== 1'b1) begin errs++; $display("FAIL wr_rsp0_valid got=%0h exp=1", rsp0_valid); end
    checks++; if (rsp_a_data !== 16'h0) begin errs++; $display("FAIL wr_rsp_a_prewrite got=%h exp=0000", rsp_a_data); end
    drv0(1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 16'h0);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL rd_ready0 got=%0h exp=1", req0_ready); end
    checks++; if (rf_reg_write !== 1'b0) begin errs++; $display("FAIL rd_rf_we got=%0h exp=0", rf_reg_write); end
    step();
    checks++; if (rsp0_valid !== 1'b1) begin errs++; $display("FAIL rd_rsp0_valid got=%0h exp=1", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errs++; $display("FAIL rd_rsp1_valid got=%0h exp=0", rsp1_valid); end
    checks++; if (rsp_a_data !== 16'hBEEF) begin errs++; $display("FAIL rd_rsp_a got=%h exp=beef", rsp_a_data); end
    checks++; if (rsp_b_data !== 16'hBEEF) begin errs++; $display("FAIL rd_rsp_b got=%h exp=beef", rsp_b_data); end
    idle();
    step();
    checks++; if (rsp0_valid !== 1'b0) begin errs++; $display("FAIL rd_rsp0_drop got=%0h exp=0", rsp0_valid); end
  endtask

  task automatic test_r0_write();
    drv0(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 16'h1234);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL r0_ready0 got=%0h exp=1", req0_ready); end
    checks++; if (rf_reg_write !== 1'b0) begin errs++; $display("FAIL r0_rf_we got=%0h exp=0", rf_reg_write); end
    step();
    drv0(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    step();
    checks++; if (rsp0_valid !== 1'b1) begin errs++; $display("FAIL r0_rsp0_valid got=%0h exp=1", rsp0_valid); end
    checks++; if (rsp_a_data !== 16'h0) begin errs++; $display("FAIL r0_rsp_a got=%h exp=0000", rsp_a_data); end
    idle();
    step();
  endtask

  task automatic test_round_robin();
    logic e0;
    drv0(1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 16'h0);
    drv1(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 16'h0);
    for (int i = 0; i < 4; i++) begin
      e0 = (i % 2 == 0);
      #1;
      checks++; if (req0_ready !== e0) begin errs++; $display("FAIL rr_ready0[%0d] got=%0h exp=%0h", i, req0_ready, e0); end
      checks++; if (req1_ready !== !e0) begin errs++; $display("FAIL rr_ready1[%0d] got=%0h exp=%0h", i, req1_ready, !e0); end
      step();
      checks++; if (rsp0_valid !== e0) begin errs++; $display("FAIL rr_rsp0[%0d] got=%0h exp=%0h", i, rsp0_valid, e0); end
      checks++; if (rsp1_valid !== !e0) begin errs++; $display("FAIL rr_rsp1[%0d] got=%0h exp=%0h", i, rsp1_valid, !e0); end
      checks++; if (rsp_a_data !== (e0 ? 16'hBEEF : 16'h0)) begin errs++; $display("FAIL rr_rsp_a[%0d] got=%h exp=%h", i, rsp_a_data, (e0 ? 16'hBEEF : 16'h0)); end
      checks++; if (rsp_b_data !== (e0 ? 16'h0 : 16'hBEEF)) begin errs++; $display("FAIL rr_rsp_b[%0d] got=%h exp=%h", i, rsp_b_data, (e0 ? 16'h0 : 16'hBEEF)); end
    end
    idle();
    step();
  endtask

  task automatic test_lock_hold();
    drv0(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 16'h0);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL hold_ready0 got=%0h exp=1", req0_ready); end
    step();
    drv0(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 16'h0);
    drv1(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    #1;
    checks++; if (req1_ready !== 1'b0) begin errs++; $display("FAIL hold_blocked1 got=%0h exp=0", req1_ready); end
    step();
    drv0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    #1;
    checks++; if (req1_ready !== 1'b0) begin errs++; $display("FAIL hold_drop_cycle1 got=%0h exp=0", req1_ready); end
    step();
    #1;
    checks++; if (req1_ready !== 1'b1) begin errs++; $display("FAIL hold_after_drop1 got=%0h exp=1", req1_ready); end
    step();
    idle();
    step();
  endtask

  task automatic test_lock_release();
    logic e0;
    drv0(1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 16'h0);
    drv1(1'b1, 1'b0, 1'b1, 5'd0, 5'd3, 16'h0);
    for (int i = 0; i < 10; i++) begin
      e0 = (i == 0) || (i == 9);
      #1;
      checks++; if (req0_ready !== e0) begin errs++; $display("FAIL lock_ready0[%0d] got=%0h exp=%0h", i, req0_ready, e0); end
      checks++; if (req1_ready !== !e0) begin errs++; $display("FAIL lock_ready1[%0d] got=%0h exp=%0h", i, req1_ready, !e0); end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_lock();
    drv0(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 16'h7777);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL mid_ready0 got=%0h exp=1", req0_ready); end
    step();
    checks++; if (rsp0_valid !== 1'b1) begin errs++; $display("FAIL mid_rsp0_pre got=%0h exp=1", rsp0_valid); end
    reset = 1'b1;
    drv1(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errs++; $display("FAIL mid_rsp0 got=%0h exp=0", rsp0_valid); end
    checks++; if (req0_ready !== 1'b0) begin errs++; $display("FAIL mid_ready0_rst got=%0h exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errs++; $display("FAIL mid_ready1_rst got=%0h exp=0", req1_ready); end
    checks++; if (rf_reg_write !== 1'b0) begin errs++; $display("FAIL mid_rf_we got=%0h exp=0", rf_reg_write); end
    step();
    reset = 1'b0;
    drv0(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 16'h0);
    #1;
    checks++; if (req1_ready !== 1'b1) begin errs++; $display("FAIL mid_ready1_after got=%0h exp=1", req1_ready); end
    step();
    checks++; if (rsp1_valid !== 1'b1) begin errs++; $display("FAIL mid_rsp1_after got=%0h exp=1", rsp1_valid); end
    idle();
    step();
  endtask

`ifdef REGFILE_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    checks++; if (stat_grant0 !== 16'd0) begin errs++; $display("FAIL st_rst_g0 got=%0d exp=0", stat_grant0); end
    drv0(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    drv1(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    step();
    step();
    drv1(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    for (int i = 0; i < 4; i++) step();
    drv0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    drv1(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    step();
    step();
    idle();
    #1;
    checks++; if (stat_grant0 !== 16'd5) begin errs++; $display("FAIL st_grant0 got=%0d exp=5", stat_grant0); end
    checks++; if (stat_grant1 !== 16'd3) begin errs++; $display("FAIL st_grant1 got=%0d exp=3", stat_grant1); end
    checks++; if (stat_conflict !== 16'd2) begin errs++; $display("FAIL st_conflict got=%0d exp=2", stat_conflict); end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errs   = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_r0_write();
    test_round_robin();
    test_lock_hold();
    test_lock_release();
    test_reset_mid_lock();
`ifdef REGFILE_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
Shares the single regfile (two combinational read ports, one clocked write port addressed by the A index) between two requesters: requester 0 is the core datapath, requester 1 is the debug/loader port. Round-robin arbitration with optional burst lock, one transaction per cycle. Drives the regfile port set directly and returns registered read data.

Parameters:
WIDTH, 16, data width of regfile and requester data.
REG_BITS, 5, register index width.
MAX_LOCK, 8, max consecutive locked beats before forced release if the other requester waits (>=1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
req0_valid / req1_valid  in  1  transaction request
req0_ready / req1_ready  out  1  transaction accepted this cycle
req0_write / req1_write  in  1  1 = write wdata to a_idx; 0 = read only
req0_lock / req1_lock  in  1  hold grant for the next beat
req0_a_idx / req1_a_idx  in  REG_BITS  A index; write target when write=1
req0_b_idx / req1_b_idx  in  REG_BITS  B read index
req0_wdata / req1_wdata  in  WIDTH  write data
rsp0_valid / rsp1_valid  out  1  response valid, one cycle after accept
rsp_a_data, rsp_b_data  out  WIDTH  registered A/B read data (shared, qualified by rspN_valid)
rf_reg_write  out  1  to regfile write enable
rf_a_idx, rf_b_idx  out  REG_BITS  to regfile indices
rf_wdata  out  WIDTH  to regfile write data
rf_a_data, rf_b_data  in  WIDTH  from regfile read ports

Behaviour:
- Reset (async, active-high): state ARB, rr pointer favours req0, lock counter 0, rspN_valid=0, rsp_a/b_data=0. rf_reg_write forced 0 while reset is high.
- readyN combinational: at most one asserted per cycle; readyN = validN & granted-to-N. Accept = validN & readyN.
- rf_* driven combinationally from the granted request. With no grant: rf_reg_write=0, indices=0, wdata=0.
- rf_reg_write = accept & write & (a_idx != 0). Writes to r0 are acked but suppressed.
- Latency 1: on accept, rf_a_data/rf_b_data are sampled into rsp_a/b_data at that edge, and rspN_valid=1 for one cycle. Read data is the pre-write value. A read accepted the cycle after a write sees the new value.
- No backpressure on responses. The requester must take the response when it is valid.
- FSM states ARB, LOCK0, LOCK1.
  - ARB: if only one is valid, grant it. If both are valid, grant the side the rr pointer favours, then flip the pointer to the other side.
  - ARB -> LOCKn: on accept from n with reqn_lock=1; counter := 1.
  - LOCKn: grant n only, including when n is idle, in which case the other requester is blocked.
  - LOCKn -> ARB: on accept with lock=0.
  - LOCKn -> ARB: counter == MAX_LOCK and the other requester is valid. This is a forced release; the pointer favours the other side.
  - LOCKn -> ARB: validn=0 and lock was dropped.
  - Each locked accept increments the counter, saturating at MAX_LOCK.
- Accepts in ARB with lock=0 do not change state.
- Reset mid-lock or mid-response drops everything; pending responses are lost.

Optional Feature:
REGFILE_ARB_STATS_EN: adds outputs stat_grant0, stat_grant1 (16-bit, wrapping, count accepts per requester) and stat_conflict (16-bit, saturating, counts cycles with both valid and one not granted); all cleared by reset. Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
Package regfile_arb_pkg:
- FSM state encoding (ARB, LOCK0, LOCK1).
- Requester ID constants REQ_CORE=0, REQ_DBG=1.
- Stats counter width constant 16.

Sub-module regfile_arb_pick: pure combinational two-way round-robin pick (valid0, valid1, rr_ptr -> gnt0, gnt1). The FSM, lock counter and response registers stay in the top.

Test Plan:
- Reset, req0 write a_idx=3 wdata=16'hBEEF, next cycle read a_idx=3 -> ready0 immediately; the following cycle rsp0_valid=1 with rsp_a_data=16'hBEEF.
- req0 write a_idx=0 wdata=16'h1234 -> ready0=1, rf_reg_write=0; a later read of r0 gives rsp_a_data=0.
- Both valid, lock=0, four cycles -> grants alternate 0,1,0,1; each rspN_valid lands exactly one cycle after its accept.
- req1 lock=1 continuously with req0 valid, MAX_LOCK=8 -> eight req1 accepts, then req0 granted on the ninth cycle.
- Assert reset while in LOCK0 with rsp0_valid=1 -> rsp0_valid=0, ready0/1=0, rf_reg_write=0 immediately; after release, req1 alone is granted within one cycle.
- With REGFILE_ARB_STATS_EN: 5 req0 + 3 req1 accepts, 2 conflict cycles -> stat_grant0=5, stat_grant1=3, stat_conflict=2.
